// File: rtl/axi_slave_mem.sv
// AXI slave memory responder: one write engine (AW/W/B) and one read engine (AR/R),
// each handling a single burst at a time, backed by a byte-strobed word array.
module axi_slave_mem #(
    parameter int              DATA_WIDTH = 32,
    parameter int              ADD_WIDTH  = 32,
    parameter int              MEM_DEPTH  = 1024,
    parameter longint unsigned MEM_BASE   = 0
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic [7:0]              awid,
    input  logic [ADD_WIDTH-1:0]    awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awlock,
    input  logic                    awvalid,
    output logic                    awready,

    input  logic [7:0]              wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,

    output logic [7:0]              bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,

    input  logic [7:0]              arid,
    input  logic [ADD_WIDTH-1:0]    araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arlock,
    input  logic                    arvalid,
    output logic                    arready,

    output logic [7:0]              rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Offset carries a borrow bit so addresses below MEM_BASE show up as negative.
    function automatic logic [64:0] byte_offset(input logic [ADD_WIDTH-1:0] addr);
        return {1'b0, 64'(addr)} - {1'b0, 64'(MEM_BASE)};
    endfunction

    function automatic logic in_range(input logic [ADD_WIDTH-1:0] addr);
        logic [64:0] off;
        off = byte_offset(addr);
        return !off[64] && (off[63:0] < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADD_WIDTH-1:0] addr);
        logic [64:0] off;
        off = byte_offset(addr);
        return IDX_W'(off >> BYTE_LSB);
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

    function automatic logic cmd_error(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        return ({29'd0, size} > 32'(BYTE_LSB)) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok(len));
    endfunction

    function automatic logic [ADD_WIDTH-1:0] step_addr(input logic [ADD_WIDTH-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
        logic [ADD_WIDTH-1:0] bytes, aligned, incr, mask;
        bytes   = ADD_WIDTH'(1) << size;
        aligned = addr & ~(bytes - ADD_WIDTH'(1));
        incr    = aligned + bytes;
        mask    = (ADD_WIDTH'(len) + ADD_WIDTH'(1)) * bytes - ADD_WIDTH'(1);
        if (burst == BURST_FIXED)
            return addr;
        else if (burst == BURST_WRAP && wrap_len_ok(len))
            return (aligned & ~mask) | (incr & mask);
        else
            return incr;
    endfunction

    // NOTE: storage has no reset; contents survive areset, and a reset loop over the array would not map to RAM.
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{awlock, arlock, wid};

    // ------------------------------------------------------------------ write engine
    w_state_e             w_state_q, w_state_d;
    logic                 awready_q, awready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic [7:0]           bid_q, bid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic [ADD_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]           w_len_q, w_len_d;
    logic [2:0]           w_size_q, w_size_d;
    logic [1:0]           w_burst_q, w_burst_d;
    logic [7:0]           w_cnt_q, w_cnt_d;
    logic                 w_err_q, w_err_d;

    logic                 w_beat_fire, w_beat_last, w_in_range;
    logic [IDX_W-1:0]     w_idx;

    assign w_beat_fire = (w_state_q == W_DATA) && wready_q && wvalid;
    assign w_beat_last = (w_cnt_q == w_len_q);
    assign w_in_range  = in_range(w_addr_q);
    assign w_idx       = word_idx(w_addr_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = cmd_error(awsize, awburst, awlen);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_beat_fire) begin
                    // Sticky error: range miss or wlast disagreeing with the beat count.
                    w_err_d = w_err_q | !w_in_range | (wlast != w_beat_last);
                    if (w_beat_last) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = step_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 8'd0;
            bresp_q   <= RESP_OKAY;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_beat_fire && w_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------ read engine
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [7:0]            rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADD_WIDTH-1:0]  r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic                  r_cmd_err_q, r_cmd_err_d;

    // Address of the beat that will be loaded on the next handshake.
    logic [ADD_WIDTH-1:0]  r_rd_addr;
    logic                  r_rd_oor;
    logic [DATA_WIDTH-1:0] r_rd_word;

    assign r_rd_addr = (r_state_q == R_IDLE) ? araddr
                                             : step_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
    assign r_rd_oor  = !in_range(r_rd_addr);
    assign r_rd_word = mem_q[word_idx(r_rd_addr)];

    always_comb begin
        r_state_d   = r_state_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rid_d       = rid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_size_d    = r_size_q;
        r_burst_d   = r_burst_q;
        r_cnt_d     = r_cnt_q;
        r_cmd_err_d = r_cmd_err_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    arready_d   = 1'b0;
                    rvalid_d    = 1'b1;
                    rid_d       = arid;
                    r_addr_d    = araddr;
                    r_len_d     = arlen;
                    r_size_d    = arsize;
                    r_burst_d   = arburst;
                    r_cnt_d     = 8'd0;
                    r_cmd_err_d = cmd_error(arsize, arburst, arlen);
                    rlast_d     = (arlen == 8'd0);
                    rdata_d     = r_rd_oor ? '0 : r_rd_word;
                    rresp_d     = (r_cmd_err_d || r_rd_oor) ? RESP_SLVERR : RESP_OKAY;
                    r_state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_rd_addr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rlast_d  = (r_cnt_d == r_len_q);
                        rdata_d  = r_rd_oor ? '0 : r_rd_word;
                        rresp_d  = (r_cmd_err_q || r_rd_oor) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= 8'd0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            r_addr_q    <= '0;
            r_len_q     <= 8'd0;
            r_size_q    <= 3'd0;
            r_burst_q   <= 2'd0;
            r_cnt_q     <= 8'd0;
            r_cmd_err_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rid_q       <= rid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            r_size_q    <= r_size_d;
            r_burst_q   <= r_burst_d;
            r_cnt_q     <= r_cnt_d;
            r_cmd_err_q <= r_cmd_err_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed plus randomized bench for axi_slave_mem; a word-array model computes beat
// addresses and responses directly from the burst rules.
module tb_axi_slave_mem;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  awid = '0, arid = '0, wid = '0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awlock = 1'b0, arlock = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [7:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] model_mem [1024];

    axi_slave_mem dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat i address straight from the burst definitions (no iteration).
    function automatic longint beat_addr(longint a, int len, int size, int burst, int i);
        longint b, al, w, base;
        b  = longint'(1) << size;
        al = a - (a % b);
        if (i == 0 || burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            w    = longint'(len + 1) * b;
            base = al - (al % w);
            return base + ((al - base + longint'(i) * b) % w);
        end
        return al + longint'(i) * b;
    endfunction

    function automatic bit cmd_err(int len, int size, int burst);
        return size > 2 || burst == 3 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic bit in_rng(longint a);
        return a >= 0 && a < 4096;
    endfunction

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input logic [31:0] data[$],
                            input logic [3:0] strb[$], input int bad_wlast, input int bdelay,
                            input string tag);
        int     cyc;
        bit     err;
        longint a;
        err = cmd_err(len, size, burst);
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        cyc = 0;
        while (awready !== 1'b1 && cyc < 20) begin @(negedge aclk); cyc++; end
        check({tag, "_awready"}, 64'(awready), 64'(1));
        if (awready !== 1'b1) begin awvalid = 1'b0; return; end
        @(negedge aclk);
        awvalid = 1'b0;
        check({tag, "_aw_accepted"}, {62'd0, awready, wready}, 64'b01);
        for (int i = 0; i <= len; i++) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) @(negedge aclk);
            wvalid = 1'b1; wdata = data[i]; wstrb = strb[i];
            wlast = (i == len) ^ (i == bad_wlast);
            if (wlast != (i == len)) err = 1'b1;
            a = beat_addr(longint'(addr), len, size, burst, i);
            if (in_rng(a)) begin
                for (int b = 0; b < 4; b++)
                    if (strb[i][b]) model_mem[int'(a >> 2)][8*b +: 8] = data[i][8*b +: 8];
            end else begin
                err = 1'b1;
            end
            @(negedge aclk);
            wvalid = 1'b0; wlast = 1'b0;
        end
        check({tag, "_bresp"}, {51'd0, wready, bvalid, bid, bresp},
              {51'd0, 1'b0, 1'b1, id, (err ? 2'b10 : 2'b00)});
        for (int k = 0; k < bdelay; k++) begin
            bready = 1'b0;
            @(negedge aclk);
            check({tag, "_b_hold"}, {53'd0, bvalid, bid, bresp},
                  {53'd0, 1'b1, id, (err ? 2'b10 : 2'b00)});
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check({tag, "_b_done"}, {62'd0, bvalid, awready}, 64'b01);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int stall_beat,
                           input int stall_cyc, input string tag, output logic [31:0] got[$]);
        int          cyc;
        longint      a;
        logic [63:0] exp;
        got = {};
        @(negedge aclk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        cyc = 0;
        while (arready !== 1'b1 && cyc < 20) begin @(negedge aclk); cyc++; end
        check({tag, "_arready"}, 64'(arready), 64'(1));
        if (arready !== 1'b1) begin arvalid = 1'b0; return; end
        @(negedge aclk);
        arvalid = 1'b0;
        check({tag, "_ar_accepted"}, 64'(arready), 64'(0));
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(longint'(addr), len, size, burst, i);
            exp = {20'd0, 1'b1, (i == len), ((cmd_err(len, size, burst) || !in_rng(a)) ? 2'b10 : 2'b00),
                   id, (in_rng(a) ? model_mem[int'(a >> 2)] : 32'd0)};
            check($sformatf("%s_beat%0d", tag, i), {20'd0, rvalid, rlast, rresp, rid, rdata}, exp);
            got.push_back(rdata);
            cyc = (i == stall_beat) ? stall_cyc : int'($urandom_range(0, 3) == 0);
            for (int k = 0; k < cyc; k++) begin
                rready = 1'b0;
                @(negedge aclk);
                check($sformatf("%s_hold%0d", tag, i), {20'd0, rvalid, rlast, rresp, rid, rdata}, exp);
            end
            rready = 1'b1;
            @(negedge aclk);
            rready = 1'b0;
        end
        check({tag, "_r_done"}, {62'd0, rvalid, arready}, 64'b01);
    endtask

    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    logic [31:0] got[$];
    logic [31:0] old_word, d0;
    int          len, size, burst;
    logic [31:0] addr;

    initial begin
        // Reset values.
        repeat (3) @(negedge aclk);
        check("reset_outputs", {6'd0, awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata}, 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("post_reset_ready", {60'd0, awready, arready, wready, bvalid}, 64'b1100);

        // Give every word a known value.
        for (int blk = 0; blk < 4; blk++) begin
            dq = {}; sq = {};
            for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
            do_write(8'(blk), 32'(blk * 1024), 255, 2, 1, dq, sq, -1, 0, "fill");
        end

        // Single write / read.
        do_write(8'h5A, 32'h10, 0, 2, 1, '{32'hDEADBEEF}, '{4'hF}, -1, 0, "single_wr");
        do_read(8'h33, 32'h10, 0, 2, 1, -1, 0, "single_rd", got);
        check("single_rd_data", 64'(got[0]), 64'hDEADBEEF);

        // INCR with partial strobe on beat 2.
        do_write(8'h01, 32'h20, 3, 2, 1, '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                 '{4'hF, 4'hF, 4'hF, 4'hF}, -1, 0, "incr_pre");
        do_write(8'h02, 32'h20, 3, 2, 1, '{32'd1, 32'd2, 32'd3, 32'd4},
                 '{4'hF, 4'hF, 4'h3, 4'hF}, -1, 0, "incr_strb");
        do_read(8'h03, 32'h20, 3, 2, 1, -1, 0, "incr_rd", got);
        check("incr_rd_words", {got[0][15:0], got[1][15:0], got[2], 32'(0)} >> 32, {16'd1, 16'd2, 32'hFFFF0003});
        check("incr_rd_word3", 64'(got[3]), 64'd4);

        // WRAP read over a 16-byte window.
        do_write(8'h04, 32'h0, 3, 2, 1, '{32'hA, 32'hB, 32'hC, 32'hD}, '{4'hF, 4'hF, 4'hF, 4'hF}, -1, 0, "wrap_pre");
        do_read(8'h05, 32'h8, 3, 2, 2, -1, 0, "wrap_rd", got);
        check("wrap_order", {got[0][15:0], got[1][15:0], got[2][15:0], got[3][15:0]}, 64'h000C_000D_000A_000B);

        // Error cases.
        do_write(8'h06, 32'h1000, 0, 2, 1, '{32'h12345678}, '{4'hF}, -1, 0, "err_range_wr");
        do_read(8'h07, 32'h0, 0, 2, 1, -1, 0, "err_range_word0", got);
        do_read(8'h08, 32'hFFC, 1, 2, 1, -1, 0, "err_cross_top", got);
        check("err_cross_top_zero", 64'(got[1]), 64'd0);
        do_write(8'h09, 32'h30, 1, 2, 3, '{32'h11, 32'h22}, '{4'hF, 4'hF}, -1, 0, "err_burst11");
        do_write(8'h0A, 32'h40, 0, 3, 1, '{32'h33}, '{4'hF}, -1, 0, "err_size");
        do_read(8'h0B, 32'h40, 2, 2, 2, -1, 0, "err_wrap_len", got);
        do_write(8'h0C, 32'h60, 2, 2, 1, '{32'h1, 32'h2, 32'h3}, '{4'hF, 4'hF, 4'hF}, 0, 0, "err_wlast_early");
        do_write(8'h0D, 32'h60, 2, 2, 1, '{32'h4, 32'h5, 32'h6}, '{4'hF, 4'hF, 4'hF}, 2, 0, "err_wlast_missing");

        // Backpressure on both response channels.
        do_write(8'h0E, 32'h50, 2, 2, 1, '{32'hA1, 32'hA2, 32'hA3}, '{4'hF, 4'hF, 4'hF}, -1, 5, "bp_wr");
        do_read(8'h0F, 32'h50, 3, 2, 1, 1, 3, "bp_rd", got);

        // Read and write of the same word on the same edge: read sees old data.
        old_word = model_mem[16];
        @(negedge aclk);
        awid = 8'h21; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = ~old_word; wstrb = 4'hF; wlast = 1'b1;
        arid = 8'h22; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check("same_edge_old", {21'd0, rvalid, bvalid, rresp, bresp, rdata}, {21'd0, 1'b1, 1'b1, 2'b00, 2'b00, old_word});
        model_mem[16] = ~old_word;
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        rready = 1'b0; bready = 1'b0;
        check("same_edge_done", {62'd0, rvalid, bvalid}, 64'd0);
        do_read(8'h23, 32'h40, 0, 2, 1, -1, 0, "same_edge_new", got);

        // Reset in the middle of a 4-beat write.
        d0 = $urandom;
        @(negedge aclk);
        awid = 8'h07; awaddr = 32'h100; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = d0; wstrb = 4'hF; wlast = 1'b0;
        @(negedge aclk);
        wdata = ~d0;
        @(negedge aclk);
        model_mem[64] = d0;
        model_mem[65] = ~d0;
        wvalid = 1'b0; areset = 1'b1;
        @(negedge aclk);
        check("midburst_reset_outputs", {6'd0, awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rresp, rdata}, 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("midburst_post_ready", {60'd0, awready, arready, wready, bvalid}, 64'b1100);
        do_write(8'h08, 32'h200, 1, 2, 1, '{32'h55, 32'h66}, '{4'hF, 4'hF}, -1, 0, "after_reset_wr");
        do_read(8'h09, 32'h100, 3, 2, 1, -1, 0, "after_reset_rd", got);
        check("after_reset_beat0", 64'(got[0]), 64'(d0));

        // Randomized bursts, each written then read back with the same command.
        for (int t = 0; t < 30; t++) begin
            burst = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) burst = 3;
            size = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) size = 3;
            if (burst == 2) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
                if ($urandom_range(0, 7) == 0) len = 2;
            end else begin
                len = int'($urandom_range(0, 7));
            end
            addr = 32'($urandom_range(0, 4095 + 64));
            if (burst == 2) addr = addr & ~((32'd1 << size) - 32'd1);
            dq = {}; sq = {};
            for (int i = 0; i <= len; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
            do_write(8'(t), addr, len, size, burst, dq, sq,
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1,
                     int'($urandom_range(0, 2)), $sformatf("rnd%0d_wr", t));
            do_read(8'(t + 100), addr, len, size, burst, int'($urandom_range(0, 7)),
                    int'($urandom_range(1, 2)), $sformatf("rnd%0d_rd", t), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Synthesizable AXI slave memory responder that sits directly behind the slave-agent interface signal set, consuming the AW/W/AR channels and producing B/R responses. It gives the slave agent's monitor and the master VIP a real, deterministic DUT target. It has one write engine and one read engine, each handling one burst at a time and running independently. Storage is a word-wide register array with byte strobes and range/protocol error reporting.

## Interface
- DATA_WIDTH, 32, data bus width in bits (32/64/128)
- ADD_WIDTH, 32, address width in bits
- MEM_DEPTH, 1024, number of DATA_WIDTH words
- MEM_BASE, 0, byte base address of the array
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset; synchronous and active-high
- awid/awaddr/awlen/awsize/awburst/awlock/awvalid  in  8/ADD_WIDTH/8/3/2/1/1  write address channel
- awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  8/DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel (wid ignored)
- wready  out  1
- bid/bresp/bvalid  out  8/2/1  write response
- bready  in  1
- arid/araddr/arlen/arsize/arburst/arlock/arvalid  in  8/ADD_WIDTH/8/3/2/1/1  read address channel
- arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  8/DATA_WIDTH/2/1/1  read data channel
- rready  in  1

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid, capture id/addr/len/size/burst and go to W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes bytes whose wstrb bit is set, then advances the address.
  - After beat awlen+1, go to W_RESP: bvalid=1, bid=captured awid. On bready, return to W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid, capture the command, load beat 0 into rdata/rresp, and go to R_DATA.
  - R_DATA: rvalid=1. Each rvalid&rready loads the next beat.
  - rlast=1 on beat arlen. The handshake on the rlast beat returns the FSM to R_IDLE.
- Address stepping, with B = 2^size:
  - FIXED (00): address constant.
  - INCR (01): addr = (addr & ~(B-1)) + B. The first beat may be unaligned.
  - WRAP (10): wrap window = (len+1)*B aligned; addr increments, then wraps to window base.
  - 11 (reserved): stepped as INCR and flagged error.
- Word index = (addr - MEM_BASE) >> log2(DATA_WIDTH/8). Full word read; strobes applied as given.
- Error conditions, reported as SLVERR (2'b10); OKAY is 2'b00:
  - byte address outside [MEM_BASE, MEM_BASE+MEM_DEPTH*DATA_WIDTH/8);
  - size > log2(DATA_WIDTH/8);
  - burst==11;
  - WRAP with len not in {1,3,7,15}.
- Write error handling: a range-error beat suppresses that beat's write. Any error in the burst makes bresp SLVERR; the flag is sticky for the burst.
- Read error handling: rresp is per-beat. An out-of-range beat returns rdata=0.
- wlast mismatch (wlast on a beat other than awlen, or missing on beat awlen): the burst still ends after awlen+1 beats, and bresp=SLVERR.
- awlock/arlock are ignored; exclusive accesses get OKAY or SLVERR, never EXOKAY.
- Memory contents are not cleared by reset.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0. FSMs go to IDLE.
- First cycle after areset deasserts: awready=1, arready=1.
- AW handshake at edge N: awready=0 and wready=1 from N.
- Last W beat at edge M: wready=0 and bvalid=1 from M. Write response latency is 1 cycle.
- AR handshake at edge N: rvalid=1 with beat 0 from N (1-cycle latency).
- Reads stream one beat per cycle while rready=1.
- rvalid/rdata/rresp/rlast/rid are held stable while rvalid&&!rready. bvalid/bid/bresp are held stable while !bready.
- awready and arready are 0 outside their IDLE states, so there is no address pipelining.
- Read and write of the same word on the same edge: the read returns the old data.
- areset asserted mid-burst: on that edge all valids/readys drop and both FSMs go to IDLE. The partial burst is abandoned; beats already written stay in memory.

## Test plan
- Single write/read: AW addr 0x10, len 0, size 2, INCR, wdata 0xDEADBEEF, wstrb 0xF -> bresp OKAY, bid=awid. AR at 0x10 -> rdata 0xDEADBEEF, rlast=1, rresp OKAY.
- INCR with strobes: 4-beat write at 0x20, data 1,2,3,4, beat 2 wstrb 0x3 over prior 0xFFFFFFFF -> readback 1,2,0xFFFF0003,4.
- WRAP: write words 0x0-0xC = A,B,C,D, then 4-beat WRAP read at 0x8 size 2 -> C,D,A,B with rlast on beat 3.
- Errors:
  - write to MEM_BASE+4*MEM_DEPTH -> bresp SLVERR, memory unchanged;
  - read crossing the top with 2 beats -> rresp OKAY then SLVERR with rdata 0;
  - awburst 11 -> bresp SLVERR.
- Backpressure: hold rready=0 for 3 cycles mid-burst and bready=0 for 5 cycles -> outputs stable, no beat lost or duplicated.
- Reset mid-burst: assert areset after beat 1 of a 4-beat write -> next cycle all outputs 0. After release a new burst completes with OKAY; beat 0 data remains in memory.
